// File: rtl/fp_align_pkg.sv
// Shared types and helpers for the FP adder alignment front end.
// Build option: FP_ALIGN_FAST_PATH_EN (consumed by fp_align_sequencer).
package fp_align_pkg;

    localparam int N     = 24;
    localparam int EXP_W = 8;
    localparam int STEP  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } align_state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] eff_exp;
        logic [N-1:0]     sig;
    } fp_unpacked_t;

    // Denormals get hidden bit 0 and effective exponent 1 so they line up with the smallest normals.
    function automatic fp_unpacked_t unpack_fp(input logic [31:0] f);
        fp_unpacked_t u;
        u.sign = f[31];
        if (f[30:23] == '0) begin
            u.eff_exp = EXP_W'(1);
            u.sig     = {1'b0, f[22:0]};
        end else begin
            u.eff_exp = f[30:23];
            u.sig     = {1'b1, f[22:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_align_step_shifter.sv
// One alignment slice: right-shift by i_k, folding every bit that leaves the LSB into bit 0.
// Bit 0 is itself part of the shifted-out set, so an existing sticky bit is preserved.
module fp_align_step_shifter #(
    parameter int W   = 27,
    parameter int K_W = 5
) (
    input  logic [W-1:0]   i_in,
    input  logic [K_W-1:0] i_k,
    output logic [W-1:0]   o_out
);

    logic w_lost;

    always_comb begin
        w_lost = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(i_k))
                w_lost = w_lost | i_in[i];
        end
        o_out    = i_in >> i_k;
        o_out[0] = o_out[0] | w_lost;
    end

endmodule

// File: rtl/fp_align_sequencer.sv
// Multi-cycle operand alignment controller: order by exponent, then shift the smaller significand.
// Build option: FP_ALIGN_FAST_PATH_EN lets d==0 / full-clamp operations skip the SHIFT state.
module fp_align_sequencer
    import fp_align_pkg::align_state_e, fp_align_pkg::fp_unpacked_t, fp_align_pkg::unpack_fp,
           fp_align_pkg::IDLE, fp_align_pkg::CMP, fp_align_pkg::SHIFT, fp_align_pkg::DONE;
#(
    parameter int N     = fp_align_pkg::N,
    parameter int EXP_W = fp_align_pkg::EXP_W,
    parameter int STEP  = fp_align_pkg::STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     big_man,
    output logic [N-1:0]     small_man,
    output logic [2:0]       grs,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_big,
    output logic             sign_small
);

    localparam int SH_W  = N + 3;
    localparam int CNT_W = $clog2(SH_W + 1);

    align_state_e r_state, w_state_nxt;

    logic [31:0]      r_op_a, r_op_b;
    logic [SH_W-1:0]  r_sh;
    logic [CNT_W-1:0] r_rem;
    logic [N-1:0]     r_big_man;
    logic [EXP_W-1:0] r_exp;
    logic             r_sign_big, r_sign_small;

    fp_unpacked_t     w_ua, w_ub, w_big, w_small;
    logic             w_swap;
    logic [EXP_W-1:0] w_diff;
    logic [CNT_W-1:0] w_d;
    logic [CNT_W-1:0] w_k;
    logic [SH_W-1:0]  w_sh_nxt;
    logic             w_fast;

    // Operand ordering and clamped exponent difference, evaluated in CMP.
    always_comb begin
        w_ua    = unpack_fp(r_op_a);
        w_ub    = unpack_fp(r_op_b);
        w_swap  = w_ub.eff_exp > w_ua.eff_exp;
        w_big   = w_swap ? w_ub : w_ua;
        w_small = w_swap ? w_ua : w_ub;
        w_diff  = w_big.eff_exp - w_small.eff_exp;
        w_d     = (w_diff > EXP_W'(SH_W)) ? CNT_W'(SH_W) : w_diff[CNT_W-1:0];
`ifdef FP_ALIGN_FAST_PATH_EN
        w_fast  = (w_d == '0) || (w_d == CNT_W'(SH_W));
`else
        w_fast  = 1'b0;
`endif
    end

    assign w_k = (r_rem > CNT_W'(STEP)) ? CNT_W'(STEP) : r_rem;

    fp_align_step_shifter #(
        .W   (SH_W),
        .K_W (CNT_W)
    ) u_step_shifter (
        .i_in  (r_sh),
        .i_k   (w_k),
        .o_out (w_sh_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = CMP;
            CMP:     w_state_nxt = w_fast ? DONE : SHIFT;
            SHIFT:   if (r_rem == w_k) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_sh         <= '0;
            r_rem        <= '0;
            r_big_man    <= '0;
            r_exp        <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                    end
                end
                CMP: begin
                    r_big_man    <= w_big.sig;
                    r_exp        <= w_big.eff_exp;
                    r_sign_big   <= w_big.sign;
                    r_sign_small <= w_small.sign;
                    r_rem        <= w_d;
                    r_sh         <= {w_small.sig, 3'b000};
`ifdef FP_ALIGN_FAST_PATH_EN
                    // A full clamp leaves only the sticky OR of the significand.
                    if (w_d == CNT_W'(SH_W)) begin
                        r_sh  <= {{(SH_W-1){1'b0}}, |w_small.sig};
                        r_rem <= '0;
                    end
`endif
                end
                SHIFT: begin
                    r_sh  <= w_sh_nxt;
                    r_rem <= r_rem - w_k;
                end
                default: ;
            endcase
        end
    end

    assign big_man    = r_big_man;
    assign small_man  = r_sh[SH_W-1:3];
    assign grs        = r_sh[2:0];
    assign exp_out    = r_exp;
    assign sign_big   = r_sign_big;
    assign sign_small = r_sign_small;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Directed bench for fp_align_sequencer: hand-computed alignment vectors, latency, stall and reset.
module tb_fp_align_sequencer;

`ifdef FP_ALIGN_FAST_PATH_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] op_a, op_b;
    logic        out_valid, out_ready;
    logic [23:0] big_man, small_man;
    logic [2:0]  grs;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small;

    int errors = 0;
    int checks = 0;

    fp_align_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_man    (big_man),
        .small_man  (small_man),
        .grs        (grs),
        .exp_out    (exp_out),
        .sign_big   (sign_big),
        .sign_small (sign_small)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic release_out();
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [23:0] e_big, input logic [23:0] e_small,
                           input logic [2:0] e_grs, input logic [7:0] e_exp,
                           input logic e_sb, input logic e_ss, input int e_lat);
        int lat;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        issue(a, b);
        wait_done(lat);
        chk({tag, ".lat"},   32'(lat),       32'(e_lat));
        chk({tag, ".big"},   32'(big_man),   32'(e_big));
        chk({tag, ".small"}, 32'(small_man), 32'(e_small));
        chk({tag, ".grs"},   32'(grs),       32'(e_grs));
        chk({tag, ".exp"},   32'(exp_out),   32'(e_exp));
        chk({tag, ".sgn"},   {30'd0, sign_big, sign_small}, {30'd0, e_sb, e_ss});
        release_out();
        chk({tag, ".idle"},  {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.data", {big_man, 8'd0} | 32'(small_man) | 32'(grs) | 32'(exp_out)
                        | 32'(sign_big) | 32'(sign_small), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst.in_ready", 32'(in_ready), 32'd1);

        run_vec("t1", 32'h40800000, 32'h3F800003, 24'h800000, 24'h200000, 3'b110, 8'd129, 0, 0, 2);
        run_vec("t2", 32'h3F800000, 32'h41200000, 24'hA00000, 24'h100000, 3'b000, 8'd130, 0, 0, 2);
        run_vec("t3", 32'h4D000000, 32'h3F800001, 24'h800000, 24'h000000, 3'b001, 8'd154, 0, 0,
                FAST ? 1 : 8);
        run_vec("t4", 32'h3F800000, 32'h3F800000, 24'h800000, 24'h800000, 3'b000, 8'd127, 0, 0,
                FAST ? 1 : 2);
        run_vec("t5d", 32'h42000000, 32'h3FFFFFFF, 24'h800000, 24'h07FFFF, 3'b111, 8'd132, 0, 0, 3);
        run_vec("tden", 32'h80000001, 32'h00400000, 24'h000001, 24'h400000, 3'b000, 8'd1, 1, 0,
                FAST ? 1 : 2);

        // Stall in DONE with in_valid pulses that must be ignored.
        issue(32'h40800000, 32'h3F800003);
        wait_done(lat);
        chk("stall.lat", 32'(lat), 32'd2);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_a     = 32'h12345678;
            op_b     = 32'h87654321;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || small_man !== 24'h200000 ||
                grs !== 3'b110 || exp_out !== 8'd129 || big_man !== 24'h800000)
                seen++;
        end
        chk("stall.hold", 32'(seen), 32'd0);
        // Handshake cycle with in_valid still high: no same-cycle re-accept.
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        chk("stall.reaccept", {30'd0, in_ready, out_valid}, 32'd2);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("stall.noemit", 32'(seen), 32'd0);

        // Reset during the long shift of the clamped case.
        issue(32'h4D000000, 32'h3F800001);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.data", {big_man, 8'd0} | 32'(small_man) | 32'(grs) | 32'(exp_out)
                         | 32'(sign_big) | 32'(sign_small), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mrst.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("mrst.noemit", 32'(seen), 32'd0);
        run_vec("post", 32'h3F800000, 32'h41200000, 24'hA00000, 24'h100000, 3'b000, 8'd130, 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
